jk_ubus_arbiter: RTL and testbench
==================================

# jk_ubus_arbiter

Round-robin bus arbiter and phase sequencer that shares one UBUS slave port among NUM_MASTERS UBUS masters. Masters request with a per-master req line. The arbiter grants one at a time, sequences the address and data phases, and muxes the winner's control and write data onto the slave side. It counts data beats from size and wait_state, and releases the bus on the last beat or on error. It sits between the master agents/interfaces and the single slave interface in the bench topology.

## Interface
- NUM_MASTERS, 4, number of requesters (legal range 1..8)
- ADDR_W, 16, UBUS address width
- DATA_W, 8, UBUS data width
- clk  in  1  bus clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m_req  in  NUM_MASTERS  per-master bus request
- m_gnt  out  NUM_MASTERS  one-hot grant, registered
- m_addr  in  NUM_MASTERS*ADDR_W  packed per-master address; master i occupies slice [i*ADDR_W +: ADDR_W]
- m_size  in  NUM_MASTERS*2  packed per-master size
- m_read, m_write, m_bip  in  NUM_MASTERS each  per-master control
- m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
- m_rdata  out  DATA_W  slave read data broadcast to all masters
- m_wait_state, m_error  out  1 each  slave response broadcast to all masters; qualified by m_gnt
- s_addr  out  ADDR_W  muxed address to slave
- s_size  out  2  muxed size to slave
- s_read, s_write, s_bip  out  1 each  muxed control to slave
- s_wdata  out  DATA_W  muxed write data to slave
- s_rdata  in  DATA_W  slave read data
- s_wait_state, s_error  in  1 each  slave response
- proto_err  out  1  sticky protocol violation flag (see Configuration)

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE**
  - If any m_req is set, the picker selects a winner, searching from index rr_ptr+1 with wrap.
  - Next edge: m_gnt is one-hot on the winner, the winner's index is latched, and the state moves to ADDR.
- **ADDR** (exactly one cycle)
  - s_addr, s_size, s_read and s_write carry the granted master's values.
  - beat_cnt loads 1<<size: size 0..3 gives 1, 2, 4 or 8 beats. beat_cnt is 4 bits.
  - If read=write=0, or read=write=1, the transaction is a no-op: go to IDLE and clear m_gnt.
  - Otherwise go to DATA.
- **DATA**
  - s_read, s_write and s_bip follow the granted master. s_wdata is muxed from the granted master only while write is set, else 0.
  - A beat completes on a cycle with s_wait_state=0. beat_cnt decrements on each completed beat.
  - Exit to IDLE when the beat with beat_cnt==1 completes, or on any cycle with s_error=1. The error cycle ends the transaction regardless of remaining beats.
  - On exit: m_gnt clears, and rr_ptr is set to the granted index.
- Outside ADDR/DATA: s_read, s_write and s_bip are 0. s_addr and s_size are 0.
- m_rdata, m_wait_state and m_error are pure pass-through of the s_* signals.
- m_req deassertion after grant is ignored. The transaction runs to completion.
- NUM_MASTERS=1: the picker is trivial, and the same master may win every arbitration.

## Timing
- Reset values:
  - state=IDLE, m_gnt=0, rr_ptr=NUM_MASTERS-1 (so master 0 wins first).
  - beat_cnt=0, proto_err=0.
  - s_read=s_write=s_bip=0, s_addr=0, s_size=0, s_wdata=0.
- Request-to-grant latency: 1 cycle. A req seen in IDLE at cycle t gives m_gnt at t+1, which is the ADDR cycle.
- Minimum transaction: 3 cycles (IDLE, ADDR, 1 data beat). Every wait cycle adds 1.
- The bus always spends at least 1 IDLE cycle between transactions. There are no back-to-back grants.
- A reset asserted mid-transaction aborts it. All outputs take their reset values at the next edge, and no beat is counted on that edge.
- Simultaneous last beat and s_error: treated as error-terminated. Either way the exit is the same.

## Configuration
- JK_UBUS_ARB_PROTO_CHK_EN defined:
  - proto_err is set and held until reset if any of the following occurs:
    - s_bip=1 on the final beat;
    - s_bip=0 on a completed non-final beat;
    - read=write=1 in ADDR.
  - proto_err does not alter sequencing.
- JK_UBUS_ARB_PROTO_CHK_EN undefined: the checker logic is absent and proto_err is tied to 0.

## Structure
- Package jk_ubus_arb_pkg holds:
  - state enum (IDLE/ADDR/DATA);
  - size-to-beats function;
  - default width constants.
- Sub-module jk_ubus_rr_picker: combinational round-robin picker. Inputs are req and rr_ptr; outputs are a one-hot grant vector and an index.

## Test plan
- Reset, then master 0 issues a write with size=0, addr=0x1234, no waits.
  - m_gnt=0001 at t+1; s_write=1 and s_addr=0x1234 in ADDR; one beat.
  - m_gnt=0 at t+3.
- All four masters hold m_req=1 continuously, each issuing one 1-beat read per grant.
  - Grant order is 0,1,2,3,0.
  - Each grant is separated by exactly one IDLE cycle.
- Master 2 reads with size=2, with s_wait_state=1 on beats 2 and 3.
  - 4 beats complete over 6 DATA cycles; m_gnt drops after the 4th zero-wait cycle.
- Master 1 writes with size=3, s_error=1 on beat 3.
  - Transaction ends after that cycle; next arbitration starts from index 2.
- Reset asserted during DATA beat 2 of 4.
  - Next edge: m_gnt=0, s_read=s_write=0, state IDLE, master 0 wins the next request.
- With JK_UBUS_ARB_PROTO_CHK_EN: master drives bip=0 on beat 1 of 2.
  - proto_err=1 and stays set; the transaction still completes 2 beats.

Source files
------------

// File: rtl/jk_ubus_arb_pkg.sv
// Shared types and helpers for the UBUS round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbiter FSM state enum, size-to-beats decode, default widths,
// and an index-width helper that stays legal for a single master.
package jk_ubus_arb_pkg;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 8;
  localparam int BEAT_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // UBUS size field encodes the burst length as a power of two (1/2/4/8).
  function automatic logic [BEAT_CNT_W-1:0] size_to_beats(input logic [1:0] size);
    return BEAT_CNT_W'(1) << size;
  endfunction

  // $clog2(1) is 0, which would give a zero-width index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jk_ubus_rr_picker.sv
// Round-robin request picker: first requester after i_rr_ptr, with wrap.
// Latency: purely combinational, no registers.
// Backpressure: none; the caller decides when to consume the pick.
//
// Ports:
//   i_req    per-master request vector
//   i_rr_ptr index of the most recently served master
//   o_gnt    one-hot pick (all zero when nothing requests)
//   o_idx    binary index of the pick (0 when nothing requests)
module jk_ubus_rr_picker
  import jk_ubus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [IDX_W-1:0]       o_idx
);

  // Offset k=1 is the master right after the last winner; k=NUM_MASTERS
  // wraps back to the last winner itself, so it only wins when alone.
  always_comb begin
    logic found;
    found = 1'b0;
    o_gnt = '0;
    o_idx = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && i_req[j] &&
            (((int'(i_rr_ptr) + k) % NUM_MASTERS) == j)) begin
          found    = 1'b1;
          o_gnt[j] = 1'b1;
          o_idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/jk_ubus_arbiter.sv
// Round-robin arbiter and address/data phase sequencer sharing one UBUS slave.
// Latency: req seen in IDLE -> m_gnt next cycle (ADDR); min transaction 3 cycles.
// Backpressure: s_wait_state stalls beat counting; s_error aborts the transfer.
//
// Ports:
//   clk, reset            bus clock, synchronous active-high reset
//   m_req / m_gnt         per-master request, registered one-hot grant
//   m_addr/size/read/write/bip/wdata  packed per-master request fields
//   m_rdata, m_wait_state, m_error    slave response broadcast to masters
//   s_addr/size/read/write/bip/wdata  winner's fields muxed to the slave
//   s_rdata, s_wait_state, s_error    slave response
//   proto_err             sticky protocol-violation flag
//
// Build option: JK_UBUS_ARB_PROTO_CHK_EN enables the bip/read-write checker
// behind proto_err; when undefined proto_err is tied low.
module jk_ubus_arbiter
  import jk_ubus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*2-1:0]      m_size,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_bip,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_wait_state,
  output logic                          m_error,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [1:0]                    s_size,
  output logic                          s_read,
  output logic                          s_write,
  output logic                          s_bip,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_wait_state,
  input  logic                          s_error,
  output logic                          proto_err
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_e              r_state;
  logic [NUM_MASTERS-1:0]  r_gnt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;

  logic [NUM_MASTERS-1:0]  w_pick_gnt;
  logic [IDX_W-1:0]        w_pick_idx;

  logic [ADDR_W-1:0]       w_sel_addr;
  logic [1:0]              w_sel_size;
  logic                    w_sel_read;
  logic                    w_sel_write;
  logic                    w_sel_bip;
  logic [DATA_W-1:0]       w_sel_wdata;

  logic                    w_in_addr;
  logic                    w_in_data;
  logic                    w_beat_done;
  logic                    w_last_beat;
  logic                    w_exit;
  logic                    w_noop;

  jk_ubus_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .i_req    (m_req),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_pick_gnt),
    .o_idx    (w_pick_idx)
  );

  // Select the latched winner's request fields.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_size  = '0;
    w_sel_read  = 1'b0;
    w_sel_write = 1'b0;
    w_sel_bip   = 1'b0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_sel_size  = m_size[i*2 +: 2];
        w_sel_read  = m_read[i];
        w_sel_write = m_write[i];
        w_sel_bip   = m_bip[i];
        w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_in_addr   = (r_state == ST_ADDR);
  assign w_in_data   = (r_state == ST_DATA);
  assign w_beat_done = w_in_data & ~s_wait_state;
  assign w_last_beat = w_beat_done & (r_beat_cnt == BEAT_CNT_W'(1));
  // An error cycle ends the transfer even while the slave is still waiting.
  assign w_exit      = w_in_data & (s_error | w_last_beat);
  assign w_noop      = (w_sel_read == w_sel_write);

  // Slave side is forced quiet whenever no transfer owns the bus.
  assign s_addr  = (w_in_addr | w_in_data) ? w_sel_addr : '0;
  assign s_size  = (w_in_addr | w_in_data) ? w_sel_size : '0;
  assign s_read  = (w_in_addr | w_in_data) & w_sel_read;
  assign s_write = (w_in_addr | w_in_data) & w_sel_write;
  assign s_bip   = w_in_data & w_sel_bip;
  assign s_wdata = (w_in_data & w_sel_write) ? w_sel_wdata : '0;

  assign m_rdata      = s_rdata;
  assign m_wait_state = s_wait_state;
  assign m_error      = s_error;
  assign m_gnt        = r_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_idx      <= '0;
      r_rr_ptr   <= IDX_W'(NUM_MASTERS - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|m_req) begin
            r_gnt   <= w_pick_gnt;
            r_idx   <= w_pick_idx;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_noop) begin
            // A no-op still uses up this master's turn so a master stuck
            // issuing no-ops cannot starve the others.
            r_gnt    <= '0;
            r_rr_ptr <= r_idx;
            r_state  <= ST_IDLE;
          end else begin
            r_beat_cnt <= size_to_beats(w_sel_size);
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_exit) begin
            r_gnt      <= '0;
            r_rr_ptr   <= r_idx;
            r_beat_cnt <= '0;
            r_state    <= ST_IDLE;
          end else if (w_beat_done) begin
            r_beat_cnt <= r_beat_cnt - BEAT_CNT_W'(1);
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef JK_UBUS_ARB_PROTO_CHK_EN
  logic r_proto_err;
  logic w_proto_viol;

  // bip must stay high through every non-final beat and drop on the last;
  // an error-terminated cycle is not a normal non-final beat.
  assign w_proto_viol = (w_in_addr & w_sel_read & w_sel_write)
                      | (w_last_beat & s_bip)
                      | (w_beat_done & ~w_last_beat & ~s_error & ~s_bip);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if (w_proto_viol) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_ubus_arbiter.sv
// Self-checking bench for jk_ubus_arbiter: scenario tasks with a grant scoreboard.
// Latency: n/a.
// Backpressure: bench drives s_wait_state/s_error directly as the slave.
module tb_jk_ubus_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 8;

`ifdef JK_UBUS_ARB_PROTO_CHK_EN
  localparam logic EXP_PERR_VIOL = 1'b1;
`else
  localparam logic EXP_PERR_VIOL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_gnt;
  logic [NM*AW-1:0] m_addr;
  logic [NM*2-1:0]  m_size;
  logic [NM-1:0]    m_read;
  logic [NM-1:0]    m_write;
  logic [NM-1:0]    m_bip;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata;
  logic             m_wait_state;
  logic             m_error;
  logic [AW-1:0]    s_addr;
  logic [1:0]       s_size;
  logic             s_read;
  logic             s_write;
  logic             s_bip;
  logic [DW-1:0]    s_wdata;
  logic [DW-1:0]    s_rdata;
  logic             s_wait_state;
  logic             s_error;
  logic             proto_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    int            dcyc;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  jk_ubus_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_req        (m_req),
    .m_gnt        (m_gnt),
    .m_addr       (m_addr),
    .m_size       (m_size),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_bip        (m_bip),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_wait_state (m_wait_state),
    .m_error      (m_error),
    .s_addr       (s_addr),
    .s_size       (s_size),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_bip        (s_bip),
    .s_wdata      (s_wdata),
    .s_rdata      (s_rdata),
    .s_wait_state (s_wait_state),
    .s_error      (s_error),
    .proto_err    (proto_err)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_req = '0; m_addr = '0; m_size = '0; m_read = '0; m_write = '0;
    m_bip = '0; m_wdata = '0; s_rdata = '0; s_wait_state = 1'b0; s_error = 1'b0;
  endtask

  task automatic set_m(input int i, input logic [AW-1:0] a, input logic [1:0] sz,
                       input logic rd, input logic wr, input logic bip,
                       input logic [DW-1:0] wd);
    m_addr[i*AW +: AW]  = a;
    m_size[i*2 +: 2]    = sz;
    m_read[i]           = rd;
    m_write[i]          = wr;
    m_bip[i]            = bip;
    m_wdata[i*DW +: DW] = wd;
  endtask

  // Steps until a grant is visible or the budget runs out; caller checks m_gnt.
  task automatic wait_gnt(input int budget, output int cyc);
    cyc = 0;
    do begin
      step(); #1; cyc++;
    end while (m_gnt === '0 && cyc < budget);
  endtask

  function automatic int gnt_idx(input logic [NM-1:0] g);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NM; i++) if (g[i] === 1'b1) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  task automatic test_reset();
    idle_inputs();
    m_req = '1;
    reset = 1'b1;
    step(); step(); #1;
    n_cmp++; if (m_gnt !== '0) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", m_gnt); end
    n_cmp++; if ({s_read, s_write, s_bip} !== 3'b000) begin n_err++; $display("FAIL rst_ctrl: got %b want 000", {s_read, s_write, s_bip}); end
    n_cmp++; if (s_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %h want 0000", s_addr); end
    n_cmp++; if ({s_size, s_wdata} !== '0) begin n_err++; $display("FAIL rst_size_wdata: got %h want 0", {s_size, s_wdata}); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", proto_err); end
    reset = 1'b0;
    m_req = '0;
    step(); #1;
    n_cmp++; if (m_gnt !== '0) begin n_err++; $display("FAIL idle_no_req_gnt: got %b want 0000", m_gnt); end
  endtask

  task automatic test_single_write();
    exp_t e;
    int cyc;
    step();
    set_m(0, 16'h1234, 2'd0, 1'b0, 1'b1, 1'b0, 8'hA5);
    m_req = 4'b0001;
    sb_q.push_back('{idx: 0, addr: 16'h1234, dcyc: 1});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (m_gnt === '0) begin
      n_err++; $display("FAIL wr_gnt_timeout: got no grant want grant");
    end else begin
      n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL wr_latency: got %0d want 1", cyc); end
      n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL wr_gnt: got %b want idx %0d", m_gnt, e.idx); end
      n_cmp++; if (s_addr !== e.addr) begin n_err++; $display("FAIL wr_addr: got %h want %h", s_addr, e.addr); end
      n_cmp++; if ({s_read, s_write} !== 2'b01) begin n_err++; $display("FAIL wr_ctrl_addr: got %b want 01", {s_read, s_write}); end
      m_req = '0;
      step(); #1;
      n_cmp++; if (m_gnt !== 4'b0001) begin n_err++; $display("FAIL wr_gnt_data: got %b want 0001", m_gnt); end
      n_cmp++; if (s_wdata !== 8'hA5) begin n_err++; $display("FAIL wr_wdata: got %h want a5", s_wdata); end
      step(); #1;
      n_cmp++; if (m_gnt !== '0) begin n_err++; $display("FAIL wr_gnt_release: got %b want 0000", m_gnt); end
      n_cmp++; if ({s_write, s_addr} !== '0) begin n_err++; $display("FAIL wr_idle_bus: got %h want 0", {s_write, s_addr}); end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int cyc;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NM; i++) set_m(i, 16'(16'h0100 + i), 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    m_req = '1;
    for (int n = 0; n < 5; n++) sb_q.push_back('{idx: n % NM, addr: 16'(16'h0100 + (n % NM)), dcyc: 1});
    for (int n = 0; n < 5; n++) begin
      wait_gnt(8, cyc);
      e = sb_q.pop_front();
      n_cmp++;
      if (m_gnt === '0) begin
        n_err++; $display("FAIL rr_timeout: got no grant want idx %0d", e.idx);
        break;
      end
      n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL rr_order[%0d]: got %b want idx %0d", n, m_gnt, e.idx); end
      n_cmp++; if (s_addr !== e.addr) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", n, s_addr, e.addr); end
      n_cmp++; if (cyc !== ((n == 0) ? 1 : 2)) begin n_err++; $display("FAIL rr_gap[%0d]: got %0d want %0d", n, cyc, (n == 0) ? 1 : 2); end
      if (n == 4) m_req = '0;
      step(); #1;
      n_cmp++; if (s_read !== 1'b1) begin n_err++; $display("FAIL rr_read[%0d]: got %b want 1", n, s_read); end
    end
    m_req = '0;
    step();
  endtask

  task automatic test_wait_states();
    exp_t e;
    int cyc;
    int k;
    int done;
    logic [DW-1:0] rd;
    step();
    set_m(2, 16'h2222, 2'd2, 1'b1, 1'b0, 1'b1, 8'h00);
    m_req = 4'b0100;
    sb_q.push_back('{idx: 2, addr: 16'h2222, dcyc: 6});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (m_gnt === '0) begin
      n_err++; $display("FAIL ws_timeout: got no grant want idx 2");
    end else begin
      n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL ws_gnt: got %b want idx %0d", m_gnt, e.idx); end
      n_cmp++; if ({s_addr, s_size} !== {e.addr, 2'd2}) begin n_err++; $display("FAIL ws_addr_size: got %h want %h", {s_addr, s_size}, {e.addr, 2'd2}); end
      m_req = '0;
      k = 0;
      done = 0;
      while (k < 20) begin
        step();
        s_wait_state = (k == 1 || k == 3);
        m_bip[2]     = (done < 3);
        rd           = 8'(k) + 8'h40;
        s_rdata      = rd;
        #1;
        if (m_gnt === '0) break;
        n_cmp++; if ({m_rdata, m_wait_state} !== {rd, (k == 1 || k == 3)}) begin n_err++; $display("FAIL ws_passthru[%0d]: got %h want %h", k, {m_rdata, m_wait_state}, {rd, (k == 1 || k == 3)}); end
        if (k == 1 || k == 3) ; else done++;
        k++;
      end
      s_wait_state = 1'b0;
      n_cmp++; if (k !== e.dcyc) begin n_err++; $display("FAIL ws_data_cycles: got %0d want %0d", k, e.dcyc); end
    end
  endtask

  task automatic test_error_abort();
    exp_t e;
    int cyc;
    int k;
    logic [DW-1:0] wd;
    step();
    set_m(1, 16'h3333, 2'd3, 1'b0, 1'b1, 1'b1, 8'h50);
    m_req = 4'b0010;
    sb_q.push_back('{idx: 1, addr: 16'h3333, dcyc: 3});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++;
    if (m_gnt === '0) begin
      n_err++; $display("FAIL err_timeout: got no grant want idx 1");
    end else begin
      n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL err_gnt: got %b want idx %0d", m_gnt, e.idx); end
      m_req = '0;
      k = 0;
      while (k < 20) begin
        step();
        s_error = (k == 2);
        wd = 8'(k) + 8'h50;
        m_wdata[1*DW +: DW] = wd;
        #1;
        if (m_gnt === '0) break;
        n_cmp++; if (s_wdata !== wd) begin n_err++; $display("FAIL err_wdata[%0d]: got %h want %h", k, s_wdata, wd); end
        n_cmp++; if (m_error !== (k == 2)) begin n_err++; $display("FAIL err_passthru[%0d]: got %b want %b", k, m_error, (k == 2)); end
        k++;
      end
      s_error = 1'b0;
      n_cmp++; if (k !== e.dcyc) begin n_err++; $display("FAIL err_data_cycles: got %0d want %0d", k, e.dcyc); end
    end
    // Everyone requests: the pointer now sits on master 1, so master 2 wins.
    for (int i = 0; i < NM; i++) set_m(i, 16'(16'h0400 + i), 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    m_req = '1;
    sb_q.push_back('{idx: 2, addr: 16'h0402, dcyc: 1});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL err_next_arb: got %b want idx %0d", m_gnt, e.idx); end
    m_req = '0;
    step(); step();
  endtask

  task automatic test_reset_midxfer();
    exp_t e;
    int cyc;
    step();
    set_m(3, 16'h4444, 2'd2, 1'b1, 1'b0, 1'b1, 8'h00);
    m_req = 4'b1000;
    sb_q.push_back('{idx: 3, addr: 16'h4444, dcyc: 4});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL rmx_gnt: got %b want idx %0d", m_gnt, e.idx); end
    m_req = '0;
    step(); #1;
    n_cmp++; if ({m_gnt, s_read} !== {4'b1000, 1'b1}) begin n_err++; $display("FAIL rmx_beat1: got %b want 10001", {m_gnt, s_read}); end
    step();
    reset = 1'b1;
    step(); #1;
    n_cmp++; if (m_gnt !== '0) begin n_err++; $display("FAIL rmx_gnt_clear: got %b want 0000", m_gnt); end
    n_cmp++; if ({s_read, s_write, s_bip, s_addr} !== '0) begin n_err++; $display("FAIL rmx_bus_clear: got %h want 0", {s_read, s_write, s_bip, s_addr}); end
    reset = 1'b0;
    for (int i = 0; i < NM; i++) set_m(i, 16'(16'h0500 + i), 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    m_req = '1;
    sb_q.push_back('{idx: 0, addr: 16'h0500, dcyc: 1});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL rmx_latency: got %0d want 1", cyc); end
    n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL rmx_first_winner: got %b want idx %0d", m_gnt, e.idx); end
    m_req = '0;
    step(); step();
  endtask

  task automatic test_noop();
    exp_t e;
    int cyc;
    step();
    set_m(2, 16'h6666, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    m_req = 4'b0100;
    sb_q.push_back('{idx: 2, addr: 16'h6666, dcyc: 0});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++; if ({gnt_idx(m_gnt), s_addr} !== {e.idx, e.addr}) begin n_err++; $display("FAIL noop_gnt_addr: got %0d/%h want %0d/%h", gnt_idx(m_gnt), s_addr, e.idx, e.addr); end
    m_req = '0;
    step(); #1;
    n_cmp++; if ({m_gnt, s_read, s_write} !== '0) begin n_err++; $display("FAIL noop_release: got %b want 0", {m_gnt, s_read, s_write}); end
  endtask

  task automatic test_proto_bip();
    exp_t e;
    int cyc;
    int k;
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL perr_clean: got %b want 0", proto_err); end
    step();
    set_m(1, 16'h7777, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    m_req = 4'b0010;
    sb_q.push_back('{idx: 1, addr: 16'h7777, dcyc: 2});
    wait_gnt(8, cyc);
    e = sb_q.pop_front();
    n_cmp++; if (gnt_idx(m_gnt) !== e.idx) begin n_err++; $display("FAIL perr_gnt: got %b want idx %0d", m_gnt, e.idx); end
    m_req = '0;
    k = 0;
    while (k < 10) begin
      step(); #1;
      if (m_gnt === '0) break;
      k++;
      if (k == 2) begin
        n_cmp++; if (proto_err !== EXP_PERR_VIOL) begin n_err++; $display("FAIL perr_set: got %b want %b", proto_err, EXP_PERR_VIOL); end
      end
    end
    n_cmp++; if (k !== e.dcyc) begin n_err++; $display("FAIL perr_beats: got %0d want %0d", k, e.dcyc); end
    step(); step(); #1;
    n_cmp++; if (proto_err !== EXP_PERR_VIOL) begin n_err++; $display("FAIL perr_sticky: got %b want %b", proto_err, EXP_PERR_VIOL); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_wait_states();
    test_error_abort();
    test_reset_midxfer();
    test_noop();
    test_proto_bip();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
